// File: rtl/alu_pipe_exec_if.sv
// Request/response bundle for the ALU execution unit.
// The master side issues operations and accepts results; the slave side is the unit itself.
interface alu_pipe_exec_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_zero;
    logic                  rsp_neg;
    logic                  rsp_carry;
    logic                  rsp_ovf;
    logic                  rsp_illegal;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_neg,
               rsp_carry, rsp_ovf, rsp_illegal
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_neg,
               rsp_carry, rsp_ovf, rsp_illegal
    );
endinterface

// File: rtl/alu_pipe_exec.sv
// Two-stage registered ALU execution unit.
// S1 captures the request; S2 computes and registers result plus flags and drives rsp_* directly.
// Ready propagates backwards combinationally so a full pipe still moves one op per cycle.
module alu_pipe_exec #(
    parameter int DATA_WIDTH = 32
) (
    input logic            clk,
    input logic            resetn,
    alu_pipe_exec_if.slave bus
);
    localparam int MSB = DATA_WIDTH - 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_NOTA = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_PASB = 3'd6;

    typedef struct packed {
        logic [2:0]            op;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  zero;
        logic                  neg;
        logic                  carry;
        logic                  ovf;
        logic                  illegal;
    } rsp_t;

    logic s1_valid, s2_valid;
    logic s1_ready, s2_ready;
    req_t s1_q;
    rsp_t s2_q, s2_d;

    logic [DATA_WIDTH-1:0] b_eff;
    logic                  cin;
    logic [DATA_WIDTH:0]   sum;

    assign s2_ready      = !s2_valid || bus.rsp_ready;
    assign s1_ready      = !s1_valid || s2_ready;
    assign bus.req_ready = s1_ready;

    // Single shared adder; SUB is A + ~B + 1 so carry-out means "no borrow".
    assign cin   = (s1_q.op == OP_SUB);
    assign b_eff = cin ? ~s1_q.b : s1_q.b;
    assign sum   = {1'b0, s1_q.a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, cin};

    // Result/flag selection from S1 contents; zero/neg come from the final result for every opcode.
    always_comb begin
        s2_d = '0;
        case (s1_q.op)
            OP_ADD: begin
                s2_d.result = sum[MSB:0];
                s2_d.carry  = sum[DATA_WIDTH];
                s2_d.ovf    = (s1_q.a[MSB] == s1_q.b[MSB]) && (sum[MSB] != s1_q.a[MSB]);
            end
            OP_SUB: begin
                s2_d.result = sum[MSB:0];
                s2_d.carry  = sum[DATA_WIDTH];
                s2_d.ovf    = (s1_q.a[MSB] != s1_q.b[MSB]) && (sum[MSB] != s1_q.a[MSB]);
            end
            OP_NOTA: s2_d.result = ~s1_q.a;
            OP_AND:  s2_d.result = s1_q.a & s1_q.b;
            OP_OR:   s2_d.result = s1_q.a | s1_q.b;
            OP_XOR:  s2_d.result = s1_q.a ^ s1_q.b;
            OP_PASB: s2_d.result = s1_q.b;
            default: s2_d.illegal = 1'b1;
        endcase
        s2_d.zero = (s2_d.result == '0);
        s2_d.neg  = s2_d.result[MSB];
    end

    // S1: capture a request whenever the stage is free or draining into S2.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_ready) begin
            s1_valid <= bus.req_valid;
            if (bus.req_valid) s1_q <= '{op: bus.req_op, a: bus.req_a, b: bus.req_b};
        end
    end

    // S2: register the computed response; held untouched while the consumer stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_q <= s2_d;
        end
    end

    assign bus.rsp_valid   = s2_valid;
    assign bus.rsp_result  = s2_q.result;
    assign bus.rsp_zero    = s2_q.zero;
    assign bus.rsp_neg     = s2_q.neg;
    assign bus.rsp_carry   = s2_q.carry;
    assign bus.rsp_ovf     = s2_q.ovf;
    assign bus.rsp_illegal = s2_q.illegal;
endmodule

// File: tb/tb_alu_pipe_exec.sv
// Bench for alu_pipe_exec at DATA_WIDTH=8: directed cases plus a randomised
// valid/ready stream, all checked against a scoreboard of expected responses.
module tb_alu_pipe_exec;
    localparam int W = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_push = 0;
    int   n_pop  = 0;
    logic rand_en = 1'b0;

    // expected/observed layout: {illegal, ovf, carry, neg, zero, result}
    logic [W+4:0] q[$];
    logic [W+4:0] cur, prev_rsp;
    logic         prev_stall = 1'b0;

    alu_pipe_exec_if #(.DATA_WIDTH(W)) bus ();

    alu_pipe_exec #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign cur = {bus.rsp_illegal, bus.rsp_ovf, bus.rsp_carry, bus.rsp_neg, bus.rsp_zero, bus.rsp_result};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+4:0] mk(input logic [W-1:0] r, input logic z, n, c, o, il);
        return {il, o, c, n, z, r};
    endfunction

    // Behavioural reference using plain integer arithmetic.
    function automatic logic [W+4:0] model(input logic [2:0] op, input logic [W-1:0] a, b);
        int ua, ub, sa, sb, s, ss;
        logic [W-1:0] r;
        logic c, o, il;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        r = '0; c = 0; o = 0; il = 0;
        case (op)
            3'd0: begin s = ua + ub; r = s[W-1:0]; c = (s > 255); ss = sa + sb; o = (ss > 127) || (ss < -128); end
            3'd1: begin s = ua - ub; r = s[W-1:0]; c = (ua >= ub); ss = sa - sb; o = (ss > 127) || (ss < -128); end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = b;
            default: il = 1;
        endcase
        return mk(r, r == 0, r[W-1], c, o, il);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request until accepted (bounded); returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b, input logic [W+4:0] exp);
        int n;
        bus.req_valid = 1'b1;
        bus.req_op = op; bus.req_a = a; bus.req_b = b;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("req_timeout", 0, 1);
        else begin q.push_back(exp); n_push++; end
        tick();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (q.size() > 0 && n < limit) begin tick(); n++; end
        chk("drain", q.size(), 0);
    endtask

    // Scoreboard pop plus stable-while-stalled check.
    always @(negedge clk) begin
        if (!resetn) prev_stall = 1'b0;
        else begin
            if (prev_stall) chk("hold", {bus.rsp_valid, cur}, {1'b1, prev_rsp});
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (q.size() == 0) chk("dup_rsp", 1, 0);
                else begin chk("rsp", cur, q.pop_front()); n_pop++; end
            end
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            prev_rsp   = cur;
        end
    end

    // Random consumer backpressure during the stress phase.
    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            bus.rsp_ready = ($urandom_range(3) != 0);
        end
    end

    initial begin
        logic [2:0]   t3op [4];
        logic [W-1:0] t3a [4], t3b [4];
        logic [W+4:0] t3e [4];
        int idx;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;

        bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0; bus.rsp_ready = 1;

        // Reset state
        @(negedge clk);
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_rsp", cur, 0);
        repeat (2) tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", bus.req_ready, 1);
        tick();

        // ADD overflow, two-cycle latency
        issue(3'd0, 8'h7F, 8'h01, mk(8'h80, 0, 1, 0, 1, 0));
        bus.req_valid = 0;
        @(negedge clk);
        chk("lat_not_yet", bus.rsp_valid, 0);
        tick();
        @(negedge clk);
        chk("lat_valid", bus.rsp_valid, 1);
        chk("add_ovf", cur, mk(8'h80, 0, 1, 0, 1, 0));
        tick();

        // Back-to-back SUBs on consecutive cycles
        issue(3'd1, 8'h05, 8'h05, mk(8'h00, 1, 0, 1, 0, 0));
        issue(3'd1, 8'h03, 8'h05, mk(8'hFE, 0, 1, 0, 0, 0));
        bus.req_valid = 0;
        @(negedge clk);
        chk("sub_eq", {bus.rsp_valid, cur}, {1'b1, mk(8'h00, 1, 0, 1, 0, 0)});
        tick();
        @(negedge clk);
        chk("sub_lt", {bus.rsp_valid, cur}, {1'b1, mk(8'hFE, 0, 1, 0, 0, 0)});
        tick();
        drain(20);

        // Four-op stream against a 3-cycle response stall
        t3op[0] = 3'd0; t3a[0] = 8'hFF; t3b[0] = 8'h01; t3e[0] = mk(8'h00, 1, 0, 1, 0, 0);
        t3op[1] = 3'd3; t3a[1] = 8'hF0; t3b[1] = 8'h3C; t3e[1] = mk(8'h30, 0, 0, 0, 0, 0);
        t3op[2] = 3'd5; t3a[2] = 8'hAA; t3b[2] = 8'hFF; t3e[2] = mk(8'h55, 0, 0, 0, 0, 0);
        t3op[3] = 3'd2; t3a[3] = 8'h0F; t3b[3] = 8'h00; t3e[3] = mk(8'hF0, 0, 1, 0, 0, 0);
        idx = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            bus.rsp_ready = (c >= 5);
            bus.req_valid = 1'b1;
            bus.req_op = t3op[idx]; bus.req_a = t3a[idx]; bus.req_b = t3b[idx];
            @(negedge clk);
            if (c == 2) begin
                chk("stall_accepts", idx, 2);
                chk("stall_rdy_low", bus.req_ready, 0);
            end
            if (bus.req_ready) begin q.push_back(t3e[idx]); n_push++; idx++; end
            tick();
        end
        bus.req_valid = 0;
        bus.rsp_ready = 1;
        drain(20);

        // Reserved opcode, then a normal op right behind it
        issue(3'd7, 8'h12, 8'h34, mk(8'h00, 1, 0, 0, 0, 1));
        issue(3'd6, 8'h12, 8'h34, mk(8'h34, 0, 0, 0, 0, 0));
        bus.req_valid = 0;
        drain(20);

        // Full pipe under backpressure, then asynchronous reset mid-cycle
        bus.rsp_ready = 0;
        issue(3'd0, 8'h01, 8'h02, mk(8'h03, 0, 0, 0, 0, 0));
        issue(3'd4, 8'h01, 8'h02, mk(8'h03, 0, 0, 0, 0, 0));
        bus.req_valid = 1; bus.req_op = 3'd0; bus.req_a = 8'h11; bus.req_b = 8'h22;
        #1;
        chk("full_rdy_low", bus.req_ready, 0);
        resetn = 1'b0;
        #1;
        chk("async_rst_vld", bus.rsp_valid, 0);
        chk("async_rst_rsp", cur, 0);
        q.delete();
        bus.req_valid = 0;
        tick();
        tick();
        resetn = 1'b1;
        bus.rsp_ready = 1;
        @(negedge clk);
        chk("post_rst_rdy", bus.req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("no_stale", bus.rsp_valid, 0);
        end
        tick();

        // Randomised stream
        n_push = 0; n_pop = 0;
        rand_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(3) == 0) begin
                bus.req_valid = 0;
                tick();
            end
            rop = 3'($urandom_range(7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            issue(rop, ra, rb, model(rop, ra, rb));
        end
        bus.req_valid = 0;
        drain(200);
        rand_en = 1'b0;
        tick();
        bus.rsp_ready = 1;
        chk("push_pop", n_pop, n_push);
        chk("rand_count", n_push, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_pipe_exec.md
Name: alu_pipe_exec

Overview:
- Registered, opcode-driven execution unit sitting on the consumer side of the team's parallel combinational ALU datapath.
- Accepts one operation per cycle (opcode plus two operands) over a valid/ready request channel.
- Computes the selected result and status flags, and returns them over a valid/ready response channel.
- Two-stage pipeline with full backpressure; no transaction is dropped or duplicated.

Parameters:
- DATA_WIDTH, 32, operand and result width in bits (legal: >= 2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_op  input  3  opcode: 0 ADD, 1 SUB, 2 NOT_A, 3 AND, 4 OR, 5 XOR, 6 PASS_B, 7 reserved.
- req_a  input  DATA_WIDTH  operand A.
- req_b  input  DATA_WIDTH  operand B.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  downstream accepts response.
- rsp_result  output  DATA_WIDTH  operation result.
- rsp_zero  output  1  rsp_result == 0.
- rsp_neg  output  1  rsp_result[DATA_WIDTH-1].
- rsp_carry  output  1  ADD: carry-out; SUB: 1 when A >= B unsigned (no borrow); else 0.
- rsp_ovf  output  1  signed overflow for ADD/SUB; else 0.
- rsp_illegal  output  1  opcode 7 was issued; result forced to 0, carry/ovf 0, zero 1.

Behaviour:
- Reset (resetn low, asynchronous):
  - Both stage-valid bits clear; rsp_valid = 0.
  - rsp_result and all flags = 0.
  - Stage data registers cleared.
  - A transaction in flight at reset is discarded.
  - req_ready = 1 from the first cycle after release.
- Stage 1 (S1): registers op, a, b on handshake (req_valid && req_ready). Holds an s1_valid bit.
- Stage 2 (S2): computes from S1 contents and registers result plus all flags. S2 outputs drive the rsp_* ports directly; s2_valid = rsp_valid.
- Ready chain, combinational, no bubbles:
  - s2_ready = !rsp_valid || rsp_ready
  - s1_ready = !s1_valid || s2_ready
  - req_ready = s1_ready
- Latency: a request accepted in cycle N appears on rsp_* in cycle N+2 when there is no backpressure. Throughput is one op per cycle.
- Stall: when rsp_valid && !rsp_ready:
  - S2 holds all outputs stable.
  - S1 holds if occupied.
  - req_ready drops only when both stages are full.
- Simultaneous events: response handshake and request handshake in the same cycle are both honoured; S1 advances into S2 and the new request enters S1 in that same edge.
- Arithmetic:
  - ADD/SUB use a DATA_WIDTH+1-bit sum; SUB is computed as A + ~B + 1.
  - Results wrap modulo 2^DATA_WIDTH.
  - ovf for ADD: sign(A) == sign(B) and sign(R) != sign(A).
  - ovf for SUB: sign(A) != sign(B) and sign(R) != sign(A).
  - NOT_A/AND/OR/XOR/PASS_B are bitwise; carry = ovf = 0.
- zero and neg are derived from the final registered result for every opcode, including illegal.
- rsp_valid never deasserts and rsp_* never change while rsp_ready is low (stable-until-accepted).
- Ordering: responses leave in request order; no reordering, no drop.

Test Plan (DATA_WIDTH=8):
- Reset release, then ADD a=0x7F b=0x01 with rsp_ready=1 -> cycle N+2: result 0x80, ovf 1, neg 1, carry 0, zero 0.
- SUB a=0x05 b=0x05, then SUB a=0x03 b=0x05 back-to-back:
  - first response: 0x00, zero 1, carry 1.
  - second response: 0xFE, carry 0, neg 1.
  - both arrive on consecutive cycles.
- Stream 4 ops (ADD 0xFF+0x01, AND 0xF0&0x3C, XOR 0xAA^0xFF, NOT_A 0x0F) with rsp_ready low for 3 cycles:
  - req_ready falls after 2 accepts.
  - outputs are held stable while stalled.
  - responses arrive in order: 0x00 (carry 1, zero 1), 0x30, 0x55, 0xF0.
- Opcode 7 with a=0x12 b=0x34 -> result 0x00, illegal 1, zero 1, carry 0, ovf 0; next PASS_B b=0x34 -> 0x34, illegal 0.
- Full pipeline with rsp_ready=0, then resetn pulsed low mid-cycle -> rsp_valid drops immediately (asynchronously); after release req_ready=1 and no stale response is emitted.
- Random valid/ready toggling over 1000 ops versus a scoreboard model -> zero mismatches, zero drops, zero duplicates.
